// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and state encoding for the LFSR index finder
package lfsr_pkg;
    localparam int LFSR_WIDTH = 8;
    localparam int LFSR_SEED  = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SCAN   = 3'd2,
        SEARCH = 3'd3,
        DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/lfsr_index_finder_step.sv
// rtl/lfsr_index_finder_step.sv - one combinational LFSR step, bit-identical to pseudo's num update
module lfsr_step #(
    parameter int WIDTH = 8,
    localparam int TW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] num,
    input  logic [TW-1:0]    tap0,
    input  logic [TW-1:0]    tap1,
    output logic [WIDTH-1:0] num_next
);
    assign num_next = {num[WIDTH-2:0], num[tap0] ^ num[tap1]};
endmodule

// File: rtl/lfsr_index_finder.sv
// rtl/lfsr_index_finder.sv - replays the pseudo LFSR from seed 1 and reports the step at which target appears
module lfsr_index_finder
    import lfsr_pkg::*;
#(
    parameter int WIDTH     = LFSR_WIDTH,
    parameter int MAX_STEPS = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] sw_in,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] index,
    output logic             found,
    output logic             bad_taps,
    output logic             busy,
    output logic             done
);
    localparam int TW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SEED   = WIDTH'(LFSR_SEED);
    localparam logic [WIDTH-1:0] MAX_J  = WIDTH'(MAX_STEPS);
    localparam logic [TW-1:0]    LAST_I = TW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mask_sh, tgt, num, num_next, j;
    logic [TW-1:0]    tap0, tap1, i;
    logic [1:0]       tcnt, tcnt_nxt;
    logic             hit, wrapped, limit;

    lfsr_step #(.WIDTH(WIDTH)) u_step (
        .num      (num),
        .tap0     (tap0),
        .tap1     (tap1),
        .num_next (num_next)
    );

    assign hit      = (num == tgt);
    assign wrapped  = (j != '0) && (num == SEED);
    assign limit    = (j == MAX_J);
    assign tcnt_nxt = (mask_sh[0] && tcnt != 2'd2) ? tcnt + 2'd1 : tcnt;

    // Controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = LOAD;
            LOAD: begin
                busy      = 1'b1;
                state_nxt = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (i == LAST_I) state_nxt = (tcnt_nxt < 2'd2) ? DONE : SEARCH;
            end
            SEARCH: begin
                busy = 1'b1;
                if (hit || wrapped || limit) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_sh  <= '0;
            tgt      <= '0;
            num      <= SEED;
            j        <= '0;
            tap0     <= '0;
            tap1     <= '0;
            tcnt     <= '0;
            i        <= '0;
            index    <= '0;
            found    <= 1'b0;
            bad_taps <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mask_sh <= sw_in;
                    tgt     <= target;
                end
                LOAD: begin
                    found    <= 1'b0;
                    bad_taps <= 1'b0;
                    index    <= '0;
                    num      <= SEED;
                    j        <= '0;
                    i        <= '0;
                    tcnt     <= '0;
                end
                SCAN: begin
                    if (mask_sh[0]) begin
                        if (tcnt == 2'd0)      tap0 <= i;
                        else if (tcnt == 2'd1) tap1 <= i;
                    end
                    tcnt    <= tcnt_nxt;
                    mask_sh <= mask_sh >> 1;
                    i       <= i + 1'b1;
                    if (i == LAST_I && tcnt_nxt < 2'd2) bad_taps <= 1'b1;
                end
                SEARCH: begin
                    // Match takes priority over both give-up conditions.
                    if (hit) begin
                        found <= 1'b1;
                        index <= j;
                    end else if (!(wrapped || limit)) begin
                        num <= num_next;
                        j   <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/lfsr_index_finder.md
Name: lfsr_index_finder

Overview:
- Inverse of the team's `pseudo` LFSR sequence generator.
- Given a tap mask on the switches and a target 8-bit value, it replays the same LFSR (seed 1, shift-left, feedback = num[tap0] ^ num[tap1]) until the state equals the target.
- Reports the step index at which the target occurs, or that the target is unreachable.
- Sits beside `pseudo` in the top level and drives the same display path with `index` instead of `num`.

Parameters:
- WIDTH, 8, LFSR, target and index width.
- MAX_STEPS, 255, last index searched before giving up; must be at most 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a search; sampled only in IDLE.
- sw_in  input  WIDTH  tap mask; captured on start.
- target  input  WIDTH  value to locate; captured on start.
- index  output  WIDTH  step count j at which the LFSR equals target; valid when done=1 and found=1.
- found  output  1  target located; held until the next start.
- bad_taps  output  1  sw_in had fewer than 2 set bits; held until the next start.
- busy  output  1  high from LOAD through SEARCH.
- done  output  1  one-cycle pulse on completion.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; index=0, found=0, bad_taps=0, busy=0, done=0. Internal regs also clear: num=1, j=0, tap0=0, tap1=0, tap count=0, scan i=0.
- Reset asserted mid-operation aborts the search immediately. No done pulse is emitted.
- IDLE: busy=0. If start=1, capture sw_in into mask_sh and target into tgt, then go to LOAD. start is ignored in every other state.
- LOAD (1 cycle): busy=1. Clear found, bad_taps, index. Set num=1, j=0, i=0, tap count=0. Go to SCAN.
- SCAN (exactly WIDTH cycles, i=0..WIDTH-1): each cycle, if mask_sh[0]=1:
  - tap count 0: tap0<=i.
  - tap count 1: tap1<=i.
  - Saturate tap count at 2.
  - Then mask_sh>>=1 and i++.
  - Taps are the two lowest set bits, tap0<tap1. Higher set bits are ignored.
  - After i=WIDTH-1: if tap count<2, set bad_taps=1 and go to DONE; else go to SEARCH.
- SEARCH (one compare per cycle), priority order:
  1. num==tgt: found=1, index=j, go to DONE.
  2. j!=0 and num==1 (period exhausted): found=0, go to DONE.
  3. j==MAX_STEPS: found=0, go to DONE.
  4. Else num<={num[WIDTH-2:0], num[tap0]^num[tap1]} and j<=j+1 (WIDTH-bit, never wraps because of rule 3).
- Target 0 is never reachable from seed 1. It terminates through rule 2 or rule 3 with found=0.
- DONE (1 cycle): done=1, busy=0, go to IDLE. index, found and bad_taps hold until the next LOAD.
- Latency for start sampled at cycle 0:
  - Match at index k: done=1 in cycle WIDTH+3+k (k=0 gives cycle 11 for WIDTH=8).
  - bad_taps: done=1 in cycle WIDTH+2.
- The step function must be bit-identical to `pseudo`'s num update, so that pseudo(seq_num=k) equals target implies index=k (first occurrence).

Decomposition:
- Shared package `lfsr_pkg`:
  - State encoding constants: IDLE, LOAD, SCAN, SEARCH, DONE.
  - WIDTH default.
  - LFSR seed constant (1).
- One sub-module is natural: `lfsr_step`, combinational, inputs num, tap0, tap1, output next num. `pseudo` is later refactored to share it.
- Controller and datapath are split in the same controller/datapath style as `pseudo`.

Test Plan:
- sw_in=0x81, target=0x0F, pulse start -> done pulse with found=1, index=3. Sequence is 01,03,07,0F.
- sw_in=0x81, target=0xFE -> found=1, index=8. The 0xFF->0xFE step proves feedback num[0]^num[7].
- sw_in=0x81, target=0x01 -> found=1, index=0, done exactly 11 cycles after start sampled.
- sw_in=0x81, target=0x00 -> found=0, bad_taps=0, done within MAX_STEPS+11 cycles.
- sw_in=0x10 (one bit) -> bad_taps=1, found=0, done at cycle 10. sw_in=0x00 gives the same result.
- Start a search with sw_in=0x81, target=0x00; drop rst_n in SEARCH -> outputs 0 immediately, no done. After release, a new start with target=0x07 gives index=2.
- Cross-check: 50 random (mask, seq_num) pairs run through `pseudo`, its num fed back as target -> index equals the first occurrence of that value, and index <= seq_num.
